// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : note_sequencer
//  Brief    : Note store and playback engine feeding the synthesizer's
//             sound_code / data_rq / data_rd handshake. Notes are appended
//             as (code, duration) pairs while idle and replayed in order,
//             each held for its programmed number of prescaled ticks.
//  Revision : 1.0 - initial release
// ============================================================================
module note_sequencer #(
   parameter int CODE_W   = 4,
   parameter int DEPTH    = 16,
   parameter int DUR_W    = 8,
   parameter int TICK_DIV = 12500000
) (
   input  logic                     CLOCK_50,
   input  logic                     resetn,
   input  logic                     wr_en,
   input  logic [CODE_W-1:0]        wr_code,
   input  logic [DUR_W-1:0]         wr_dur,
   input  logic                     clear,
   input  logic                     play,
   input  logic                     stop,
   input  logic                     loop_en,
   input  logic                     data_rq,
   output logic [CODE_W-1:0]        sound_code,
   output logic                     data_rd,
   output logic                     playing,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_CW = c_AW + 1;
   localparam int c_PW = $clog2(TICK_DIV);
   localparam int c_MW = CODE_W + DUR_W;

   localparam logic [c_CW-1:0]  c_DEPTH = c_CW'(DEPTH);
   localparam logic [c_PW-1:0]  c_PMAX  = c_PW'(TICK_DIV - 1);
   localparam logic [DUR_W-1:0] c_DUR1  = DUR_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_PLAY  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [c_MW-1:0]     r_mem [DEPTH];
   logic [c_AW-1:0]     r_rp;
   logic [CODE_W-1:0]   r_cur_code;
   logic [DUR_W-1:0]    r_dur_cnt;
   logic [c_PW-1:0]     r_presc;
   logic [c_CW-1:0]     w_count_nxt;

   logic                w_wr_ok;
   logic                w_wrap;
   logic                w_last_tick;
   logic                w_more;
   logic                w_present;
   logic [c_MW-1:0]     w_fetch_word;
   logic [DUR_W-1:0]    w_fetch_dur;
   logic [CODE_W-1:0]   w_fetch_code;

   // A write only lands while idle, not full, and not overridden by clear.
   assign w_wr_ok      = (r_state == S_IDLE) && wr_en && !clear && (count != c_DEPTH);
   assign w_wrap       = (r_presc == c_PMAX);
   assign w_last_tick  = w_wrap && (r_dur_cnt == c_DUR1);
   assign w_more       = ({1'b0, r_rp} < (count - c_CW'(1)));
   assign w_fetch_word = r_mem[r_rp];
   assign w_fetch_dur  = w_fetch_word[DUR_W-1:0];
   assign w_fetch_code = w_fetch_word[c_MW-1:DUR_W];
   // Stop suppresses the handshake in the same cycle playing drops.
   assign w_present    = (r_state == S_PLAY) && data_rq && !stop;

   // Next-state and next-count decode.
   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = count;
      case (r_state)
         S_IDLE: begin
            if (clear)
               w_count_nxt = '0;
            else if (w_wr_ok)
               w_count_nxt = count + c_CW'(1);
            if (play && (count != '0))
               w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            w_state_nxt = stop ? S_IDLE : S_PLAY;
         end
         S_PLAY: begin
            if (stop)
               w_state_nxt = S_IDLE;
            else if (w_last_tick)
               w_state_nxt = (w_more || loop_en) ? S_FETCH : S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Note memory write port; contents are not reset.
   always_ff @(posedge CLOCK_50) begin
      if (w_wr_ok)
         r_mem[count[c_AW-1:0]] <= {wr_code, wr_dur};
   end

   // Playback datapath, status flags and registered handshake outputs.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_rp       <= '0;
         r_cur_code <= '0;
         r_dur_cnt  <= '0;
         r_presc    <= '0;
         count      <= '0;
         full       <= 1'b0;
         empty      <= 1'b1;
         playing    <= 1'b0;
         data_rd    <= 1'b0;
         sound_code <= '0;
      end else begin
         count      <= w_count_nxt;
         full       <= (w_count_nxt == c_DEPTH);
         empty      <= (w_count_nxt == '0);
         playing    <= (w_state_nxt != S_IDLE);
         data_rd    <= w_present;
         sound_code <= w_present ? r_cur_code : '0;
         case (r_state)
            S_IDLE: begin
               r_rp <= '0;
            end
            S_FETCH: begin
               r_cur_code <= w_fetch_code;
               // A zero duration still plays for one tick.
               r_dur_cnt  <= (w_fetch_dur == '0) ? c_DUR1 : w_fetch_dur;
               r_presc    <= '0;
            end
            S_PLAY: begin
               r_presc <= w_wrap ? '0 : r_presc + c_PW'(1);
               if (w_wrap)
                  r_dur_cnt <= r_dur_cnt - c_DUR1;
               if (w_last_tick && !stop)
                  r_rp <= w_more ? r_rp + c_AW'(1) : '0;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
